// File: rtl/result_reader2.sv
// Layer-2 result drain: reads result memory addresses 0..DEPTH-1 in order and
// streams the words on a valid/ready port through a 2-entry skid FIFO.
module result_reader2 #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  issue_reg;
   logic [CNT_W-1:0]  pop_reg;
   logic              inflight_reg;
   logic [1:0]        count_reg;
   logic              wr_ptr_reg;
   logic              rd_ptr_reg;
   logic [DATA_W-1:0] fifo_mem [0:1];
   logic              pop;
   logic [2:0]        occupancy;

   assign out_valid = (count_reg != 2'd0);
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? fifo_mem[rd_ptr_reg] : '0;
   assign out_last  = out_valid && (pop_reg == LAST_C);
   assign mem_addr  = issue_reg[ADDR_W-1:0];

   // Words that will still be held after this cycle's pop; a new read may
   // only be issued while this leaves room in the 2-entry buffer.
   assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

   always_comb begin
      state_next = state_reg;
      mem_rd     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if ((issue_reg < DEPTH_C) && (occupancy < 3'd2)) mem_rd = 1'b1;
            if (pop && (pop_reg == LAST_C)) state_next = FIN;
         end
         FIN: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         issue_reg    <= '0;
         pop_reg      <= '0;
         inflight_reg <= 1'b0;
         count_reg    <= 2'd0;
         wr_ptr_reg   <= 1'b0;
         rd_ptr_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= mem_rd;
         if (state_reg == IDLE && start) begin
            issue_reg  <= '0;
            pop_reg    <= '0;
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
         end else begin
            if (mem_rd) issue_reg <= issue_reg + CNT_W'(1);
            if (pop) begin
               pop_reg    <= pop_reg + CNT_W'(1);
               rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
            count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
         end
      end
   end

   // Read data lands one cycle after the strobe, so the write is keyed on inflight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      end else if (inflight_reg) begin
         fifo_mem[wr_ptr_reg] <= mem_data;
      end
   end

endmodule

// File: tb/tb_result_reader2.sv
// Self-checking bench for result_reader2: cycle table for the nominal drain,
// randomized backpressure against an in-order stream model, and corner sequences.
module tb_result_reader2;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;

   result_reader2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem_model [0:DEPTH-1];
   always @(posedge clk) if (mem_rd) mem_data <= mem_model[mem_addr];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Stream monitor: expected stream is simply mem_model[0..DEPTH-1] in order.
   int rd_cnt = 0;
   int xfer_cnt = 0;
   int done_cnt = 0;
   logic stall_prev = 1'b0;
   logic [DATA_W-1:0] held_data;
   logic held_last;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst || (start && !busy)) begin
            rd_cnt = 0; xfer_cnt = 0; done_cnt = 0; stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("stall_valid", 32'(out_valid), 32'(1));
               chk("stall_data", 32'(out_data), 32'(held_data));
               chk("stall_last", 32'(out_last), 32'(held_last));
            end
            chk("occupancy_le2", 32'(rd_cnt - xfer_cnt <= 2), 32'(1));
            if (mem_rd) begin
               chk("mem_addr_order", 32'(mem_addr), 32'(rd_cnt));
               rd_cnt++;
            end
            if (out_valid && out_ready) begin
               if (xfer_cnt < DEPTH) begin
                  chk("xfer_data", 32'(out_data), 32'(mem_model[xfer_cnt]));
                  chk("xfer_last", 32'(out_last), 32'(xfer_cnt == DEPTH - 1));
               end else begin
                  chk("xfer_extra", 32'(xfer_cnt), 32'(DEPTH - 1));
               end
               xfer_cnt++;
            end
            if (done) done_cnt++;
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
         end
      end
   end

   typedef struct {
      logic start_in;
      logic rd;
      int   addr;
      logic valid;
      int   data;
      logic last;
      logic dn;
      logic bsy;
   } vec_t;

   vec_t tab [1:22];

   task automatic fill_linear();
      for (int a = 0; a < DEPTH; a++) mem_model[a] = DATA_W'(3 * a + 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_rd"}, 32'(mem_rd), 32'(0));
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
      chk({tag, "_out_data"}, 32'(out_data), 32'(0));
      chk({tag, "_out_last"}, 32'(out_last), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_done"}, 32'(done), 32'(0));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'(1));
   endtask

   initial begin
      logic found;
      rst = 1'b0; start = 1'b0; out_ready = 1'b0;

      for (int c = 1; c <= 22; c++) begin
         tab[c].start_in = 1'b0;
         tab[c].rd    = (c <= DEPTH);
         tab[c].addr  = c - 1;
         tab[c].valid = (c >= 3) && (c <= DEPTH + 2);
         tab[c].data  = 3 * (c - 3) + 1;
         tab[c].last  = (c == DEPTH + 2);
         tab[c].dn    = (c == DEPTH + 3);
         tab[c].bsy   = (c <= DEPTH + 3);
      end

      // Reset held with start asserted.
      start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk_reset_outputs("reset");
      end
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b1;
      @(posedge clk); #1;

      // Full throughput, then the same with start pulses while busy.
      fill_linear();
      out_ready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         pulse_start();
         for (int c = 1; c <= 22; c++) begin
            start = (pass == 1) && (c == 5 || c == DEPTH + 3);
            @(negedge clk);
            chk($sformatf("p%0d_c%0d_mem_rd", pass, c), 32'(mem_rd), 32'(tab[c].rd));
            if (tab[c].rd)
               chk($sformatf("p%0d_c%0d_mem_addr", pass, c), 32'(mem_addr), 32'(tab[c].addr));
            chk($sformatf("p%0d_c%0d_out_valid", pass, c), 32'(out_valid), 32'(tab[c].valid));
            if (tab[c].valid)
               chk($sformatf("p%0d_c%0d_out_data", pass, c), 32'(out_data), 32'(tab[c].data));
            chk($sformatf("p%0d_c%0d_out_last", pass, c), 32'(out_last), 32'(tab[c].last));
            chk($sformatf("p%0d_c%0d_done", pass, c), 32'(done), 32'(tab[c].dn));
            chk($sformatf("p%0d_c%0d_busy", pass, c), 32'(busy), 32'(tab[c].bsy));
            @(posedge clk); #1;
         end
         start = 1'b0;
         chk($sformatf("p%0d_done_count", pass), 32'(done_cnt), 32'(1));
         chk($sformatf("p%0d_xfer_count", pass), 32'(xfer_cnt), 32'(DEPTH));
         $display("drain pass %0d: %0d words, %0d reads", pass, xfer_cnt, rd_cnt);
      end

      // Random backpressure with random memory contents.
      for (int r = 0; r < 3; r++) begin
         logic seen;
         for (int a = 0; a < DEPTH; a++) mem_model[a] = DATA_W'($urandom);
         pulse_start();
         seen = 1'b0;
         for (int i = 0; i < 300 && !seen; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
         end
         chk($sformatf("rand%0d_done_seen", r), 32'(seen), 32'(1));
         chk($sformatf("rand%0d_xfer_count", r), 32'(xfer_cnt), 32'(DEPTH));
         chk($sformatf("rand%0d_rd_count", r), 32'(rd_cnt), 32'(DEPTH));
         chk($sformatf("rand%0d_done_count", r), 32'(done_cnt), 32'(1));
         $display("random drain %0d: %0d words, %0d reads", r, xfer_cnt, rd_cnt);
      end

      // Reset mid-drain, then restart from address 0.
      fill_linear();
      out_ready = 1'b1;
      pulse_start();
      for (int i = 1; i < 8; i++) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("mid_reset");
      pulse_start();
      @(negedge clk);
      chk("restart_mem_rd", 32'(mem_rd), 32'(1));
      chk("restart_mem_addr", 32'(mem_addr), 32'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("restart_out_valid", 32'(out_valid), 32'(1));
      chk("restart_out_data", 32'(out_data), 32'(1));
      @(posedge clk); #1;
      wait_done("restart");
      chk("restart_xfer_count", 32'(xfer_cnt), 32'(DEPTH));
      $display("restart drain: %0d words", xfer_cnt);

      // Stall on the last word.
      out_ready = 1'b1;
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (out_last) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk("last_found", 32'(found), 32'(1));
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_last", k), 32'(out_last), 32'(1));
         chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'(1));
         chk($sformatf("stall%0d_data", k), 32'(out_data), 32'(3 * (DEPTH - 1) + 1));
         chk($sformatf("stall%0d_done", k), 32'(done), 32'(0));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_done", 32'(done), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("fin_done", 32'(done), 32'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("after_fin_done", 32'(done), 32'(0));
      chk("after_fin_busy", 32'(busy), 32'(0));
      chk("stall_done_count", 32'(done_cnt), 32'(1));
      $display("stall-on-last drain: %0d words, %0d done pulses", xfer_cnt, done_cnt);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/result_reader2.md
# result_reader2

Layer-2 result drain controller. After the layer-2 controller has written its output feature map into the result memory and pulsed its completion flag, this block reads that memory back. It reads addresses 0 to DEPTH-1 in order and streams the words out on a valid/ready interface, marking the final word with `out_last`. It is the read-side counterpart of the layer-2 write path, and it runs at one word per cycle when the sink does not stall.

## Interface
Parameters:
- `DATA_W`, default 8: result word width.
- `DEPTH`, default 16: number of result words (≥2).
- `ADDR_W`, default 4: memory address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: one-cycle pulse from the layer-2 controller's done output; begins a drain.
- `mem_rd`, output, 1: result memory read strobe.
- `mem_addr`, output, ADDR_W: read address; meaningful only while `mem_rd`=1.
- `mem_data`, input, DATA_W: read data; valid exactly one cycle after the `mem_rd` cycle.
- `out_data`, output, DATA_W: streamed result word.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: sink accepts the word; a transfer occurs when `out_valid` and `out_ready` are both 1.
- `out_last`, output, 1: the current word is address DEPTH-1.
- `busy`, output, 1: a drain is in progress.
- `done`, output, 1: one-cycle pulse after the last transfer.

## Operation
State machine with three states: IDLE, RUN, FIN.
- IDLE → RUN: on `start`=1. Clear the issue counter, the pop counter and the FIFO.
- RUN → FIN: on the transfer of word DEPTH-1.
- FIN → IDLE: unconditionally after one cycle. `done`=1 in FIN only.
- `start` is ignored in RUN and FIN.

Read issue:
- In RUN, `mem_rd`=1 when issued < DEPTH and (fifo_count + inflight − pop) < 2.
- pop = 1 when a transfer occurs this cycle.
- inflight = 1 when `mem_rd` was 1 in the previous cycle.
- `mem_addr` equals the issue counter, which increments on each `mem_rd`.
- At most 2 words are ever buffered or in flight; no read is issued that could overflow the buffer.

Buffer:
- 2-entry FIFO.
- `mem_data` is written into it in the cycle after `mem_rd`.
- The FIFO head drives `out_data`.
- `out_valid` = (fifo_count > 0).
- `out_last` = `out_valid` and (pop counter == DEPTH-1).
- The pop counter increments on each transfer.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- A write and a pop in the same cycle leave the count unchanged; data order is preserved.

Counters:
- The issue and pop counters are ADDR_W+1 bits wide so that DEPTH fits.
- They never wrap within a drain.
- `busy` = 1 in RUN and FIN.

Reset:
- Applied with `rst`=0 at a clock edge, including mid-drain.
- Forces IDLE, clears the counters and the FIFO, and discards any in-flight read data.
- Reset values: `mem_rd`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled at edge E0; state is RUN from E0.
- Cycle 1 (after E0): `mem_rd`=1, `mem_addr`=0.
- Cycle 2: `mem_data`(0) is present; it is written to the FIFO at the end of cycle 2. `mem_rd`=1, `mem_addr`=1.
- Cycle 3: `out_valid`=1, `out_data`=word 0.
- With `out_ready` held at 1, word k transfers in cycle 3+k, and `out_last`=1 in cycle 3+DEPTH-1.
- FIN (`done`=1) falls in cycle 3+DEPTH; `busy` drops the cycle after.
- Stall: if `out_ready`=0, at most one additional read completes into the FIFO and then `mem_rd` stays 0. After `out_ready` returns to 1, a transfer occurs in that same cycle and `mem_rd` may reassert in that same cycle.
- `out_ready` is not required before `out_valid`; the output logic has no combinational path from `out_ready` to `out_valid`.

## Test plan
- **Reset values:** hold `rst`=0 for 2 cycles with `start`=1 → all outputs 0, state IDLE, `mem_rd` never asserted.
- **Full throughput:** DEPTH=16, memory[a]=3a+1, `out_ready`=1 → `mem_rd` in cycles 1..16 with addresses 0..15. `out_data` = 1,4,…,46 in cycles 3..18, `out_last` only in cycle 18, `done` in cycle 19.
- **Random backpressure:** `out_ready` random at 50% → 16 words in order, no duplicates or losses. `out_data` stable during stalls, fifo_count+inflight ≤ 2 always, exactly 16 `mem_rd` pulses.
- **Start while busy:** pulse `start` in cycles 5 and 19 (FIN) → ignored. The stream is identical to the full-throughput case and only one `done` pulse occurs.
- **Reset mid-drain:** `rst`=0 in cycle 8 → outputs at reset values next cycle. A following `start` restarts from address 0 and the first `out_data`=1.
- **Stall on last word:** hold `out_ready`=0 from the cycle `out_last` rises for 4 cycles → `out_last`, `out_valid` and `out_data`=46 hold. `done` pulses exactly once, one cycle after `out_ready` returns to 1.
